// File: rtl/memdump_viewer_pkg.sv
// memdump_viewer_pkg: shared types and helpers for the post-halt memory viewer.
//   memdump_state_t : controller states (IDLE, FETCH, SHOW)
//   memdump_evt_t   : key/scan event kinds, also used as the one-deep pending slot
//   WBYTES          : bytes per memory word (address stride)
package memdump_viewer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SHOW  = 2'd2
  } memdump_state_t;

  typedef enum logic [1:0] {
    EVT_NONE = 2'd0,
    EVT_STEP = 2'd1,
    EVT_LOAD = 2'd2
  } memdump_evt_t;

  localparam int unsigned WBYTES = 4;

  // Combine two events: a load always dominates, and two steps collapse into one.
  function automatic memdump_evt_t evt_merge(input memdump_evt_t a, input memdump_evt_t b);
    memdump_evt_t r;
    if ((a == EVT_LOAD) || (b == EVT_LOAD)) begin
      r = EVT_LOAD;
    end else if ((a == EVT_STEP) || (b == EVT_STEP)) begin
      r = EVT_STEP;
    end else begin
      r = EVT_NONE;
    end
    return r;
  endfunction

  // Force a byte address onto a word boundary.
  function automatic logic [15:0] word_align(input logic [15:0] a);
    return {a[15:2], 2'b00};
  endfunction

endpackage

// File: rtl/memdump_viewer_key_debounce.sv
// key_debounce: raw active-low board key -> one-cycle press pulse.
//   CLK, RST : clock, synchronous active-high reset
//   raw_n    : asynchronous raw key level (0 = pressed)
//   press_p  : one-cycle pulse on an accepted released->pressed transition
// A 2-flop synchronizer feeds a stable-count debouncer; the accepted level only
// follows the synchronized level after DEBOUNCE_CYCLES consecutive cycles of
// disagreement. The pulse is registered one cycle after acceptance.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic CLK,
  input  logic RST,
  input  logic raw_n,
  output logic press_p
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             acc_q;
  logic             acc_dly_q;
  logic [CNT_W-1:0] cnt_q;
  logic             press_q;

  // Synchronizer, stable counter, accepted level and press pulse.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      acc_q     <= 1'b1;
      acc_dly_q <= 1'b1;
      cnt_q     <= '0;
      press_q   <= 1'b0;
    end else begin
      sync1_q   <= raw_n;
      sync2_q   <= sync1_q;
      acc_dly_q <= acc_q;
      press_q   <= acc_dly_q & ~acc_q;
      // For a 1-bit level, agreeing with the accepted level is exactly the
      // "level changed back" case, so the count restarts there.
      if (sync2_q == acc_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        acc_q <= sync2_q;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign press_p = press_q;

endmodule

// File: rtl/memdump_viewer.sv
// memdump_viewer: post-halt memory inspection controller.
//   CLK, RST       : clock, synchronous active-high reset
//   halt           : CPU halted; viewer runs only while high
//   base_addr[15:0]: switch byte address (low two bits ignored)
//   load_n, step_n : raw active-low keys (load base / advance one word)
//   mem_ren        : memory read request (held until mem_wait drops)
//   mem_addr[31:0] : {16'b0, current word address}
//   mem_wait       : memory busy
//   mem_load[31:0] : read data, valid in the completing cycle
//   disp_word/disp_addr/disp_valid : last completed read for this halt session
// Optional build macro MEMDUMP_AUTOSCAN_EN adds a timed auto-step while showing.
// All outputs come from registers or from the registered state only.
module memdump_viewer
  import memdump_viewer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned SCAN_CYCLES     = 50000000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        halt,
  input  logic [15:0] base_addr,
  input  logic        load_n,
  input  logic        step_n,
  output logic        mem_ren,
  output logic [31:0] mem_addr,
  input  logic        mem_wait,
  input  logic [31:0] mem_load,
  output logic [31:0] disp_word,
  output logic [15:0] disp_addr,
  output logic        disp_valid
);

  logic load_p;
  logic step_p;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_load_key (
    .CLK     (CLK),
    .RST     (RST),
    .raw_n   (load_n),
    .press_p (load_p)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_key (
    .CLK     (CLK),
    .RST     (RST),
    .raw_n   (step_n),
    .press_p (step_p)
  );

  memdump_state_t state_q, state_d;
  memdump_evt_t   pend_q, pend_d;
  memdump_evt_t   key_evt_s;
  memdump_evt_t   evt_s;
  memdump_evt_t   show_evt_s;
  logic [15:0]    cur_addr_q, cur_addr_d;
  logic [31:0]    disp_word_q, disp_word_d;
  logic [15:0]    disp_addr_q, disp_addr_d;
  logic           disp_valid_q, disp_valid_d;

  // Simultaneous presses: load wins and the step is discarded.
  assign key_evt_s = load_p ? EVT_LOAD : (step_p ? EVT_STEP : EVT_NONE);

`ifdef MEMDUMP_AUTOSCAN_EN
  localparam int unsigned SCAN_W = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  logic [SCAN_W-1:0] scan_cnt_q;
  logic              scan_tick_s;

  assign scan_tick_s = (state_q == SHOW) && (scan_cnt_q == SCAN_W'(SCAN_CYCLES - 1));
  // Manual keys take priority over the scan tick.
  assign evt_s = (key_evt_s != EVT_NONE) ? key_evt_s : (scan_tick_s ? EVT_STEP : EVT_NONE);

  // Scan period counter: runs only while showing, restarts on any key event.
  always_ff @(posedge CLK) begin
    if (RST) begin
      scan_cnt_q <= '0;
    end else if ((state_q != SHOW) || (key_evt_s != EVT_NONE) || scan_tick_s) begin
      scan_cnt_q <= '0;
    end else begin
      scan_cnt_q <= scan_cnt_q + SCAN_W'(1);
    end
  end
`else
  assign evt_s = key_evt_s;
`endif

  // In SHOW a pending event and a fresh one are folded with the same rule.
  assign show_evt_s = evt_merge(pend_q, evt_s);

  // State and datapath registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      pend_q       <= EVT_NONE;
      cur_addr_q   <= 16'h0000;
      disp_word_q  <= 32'h0000_0000;
      disp_addr_q  <= 16'h0000;
      disp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pend_q       <= pend_d;
      cur_addr_q   <= cur_addr_d;
      disp_word_q  <= disp_word_d;
      disp_addr_q  <= disp_addr_d;
      disp_valid_q <= disp_valid_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d      = state_q;
    pend_d       = pend_q;
    cur_addr_d   = cur_addr_q;
    disp_word_d  = disp_word_q;
    disp_addr_d  = disp_addr_q;
    disp_valid_d = disp_valid_q;
    case (state_q)
      IDLE: begin
        pend_d       = EVT_NONE;
        disp_valid_d = 1'b0;
        if (halt) begin
          cur_addr_d = word_align(base_addr);
          state_d    = FETCH;
        end else begin
          state_d = IDLE;
        end
      end
      FETCH: begin
        if (!halt) begin
          // Abandon the read; the displayed word is kept but marked stale.
          state_d      = IDLE;
          pend_d       = EVT_NONE;
          disp_valid_d = 1'b0;
        end else begin
          pend_d = evt_merge(pend_q, evt_s);
          if (!mem_wait) begin
            disp_word_d  = mem_load;
            disp_addr_d  = cur_addr_q;
            disp_valid_d = 1'b1;
            state_d      = SHOW;
          end else begin
            state_d = FETCH;
          end
        end
      end
      SHOW: begin
        pend_d = EVT_NONE;
        if (!halt) begin
          state_d      = IDLE;
          disp_valid_d = 1'b0;
        end else if (show_evt_s == EVT_LOAD) begin
          cur_addr_d = word_align(base_addr);
          state_d    = FETCH;
        end else if (show_evt_s == EVT_STEP) begin
          cur_addr_d = cur_addr_q + 16'(WBYTES);
          state_d    = FETCH;
        end else begin
          state_d = SHOW;
        end
      end
      default: begin
        state_d      = IDLE;
        pend_d       = EVT_NONE;
        disp_valid_d = 1'b0;
      end
    endcase
  end

  assign mem_ren    = (state_q == FETCH);
  assign mem_addr   = {16'h0000, cur_addr_q};
  assign disp_word  = disp_word_q;
  assign disp_addr  = disp_addr_q;
  assign disp_valid = disp_valid_q;

endmodule

// File: tb/tb_memdump_viewer.sv
// tb_memdump_viewer: directed + randomized bench for memdump_viewer.
// The bench plays the memory (random data, programmable stall length) and
// tracks the expected word address arithmetically from the key actions.
module tb_memdump_viewer;

  logic        CLK = 1'b0;
  logic        RST;
  logic        halt;
  logic [15:0] base_addr;
  logic        load_n;
  logic        step_n;
  logic        mem_ren;
  logic [31:0] mem_addr;
  logic        mem_wait;
  logic [31:0] mem_load;
  logic [31:0] disp_word;
  logic [15:0] disp_addr;
  logic        disp_valid;

  memdump_viewer #(.DEBOUNCE_CYCLES(4), .SCAN_CYCLES(16)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .halt       (halt),
    .base_addr  (base_addr),
    .load_n     (load_n),
    .step_n     (step_n),
    .mem_ren    (mem_ren),
    .mem_addr   (mem_addr),
    .mem_wait   (mem_wait),
    .mem_load   (mem_load),
    .disp_word  (disp_word),
    .disp_addr  (disp_addr),
    .disp_valid (disp_valid)
  );

  always #5 CLK = ~CLK;

  int          total = 0;
  int          bad   = 0;
  int          wait_left = 0;
  bit          rand_load = 1'b0;
  logic [31:0] load_val = 32'h0;
  logic [31:0] last_word = 32'h0;
  int          ren_run = 0;
  logic [15:0] ren_addr0 = 16'h0;
  logic [15:0] exp_cur = 16'h0;
  logic [15:0] log_addr[$];
  logic [31:0] log_data[$];
  int          log_run[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: act as memory just after the edge, observe at the falling edge.
  task automatic tick();
    @(posedge CLK);
    #1;
    mem_wait = mem_ren && (wait_left > 0);
    if (mem_wait) wait_left--;
    mem_load = rand_load ? $urandom : load_val;
    @(negedge CLK);
    if (mem_ren) begin
      if (ren_run > 0) check("addr_hold", mem_addr, {16'h0000, ren_addr0});
      else ren_addr0 = mem_addr[15:0];
      if (mem_wait) check("stall_disp", disp_word, last_word);
      ren_run++;
      if (!mem_wait) begin
        log_addr.push_back(mem_addr[15:0]);
        log_data.push_back(mem_load);
        log_run.push_back(ren_run);
        last_word = mem_load;
        ren_run = 0;
      end
    end else begin
      ren_run = 0;
    end
  endtask

  task automatic do_press(input bit is_load, input int hold, input int rel);
    if (is_load) load_n = 1'b0; else step_n = 1'b0;
    repeat (hold) tick();
    load_n = 1'b1;
    step_n = 1'b1;
    repeat (rel) tick();
  endtask

  // Exactly one new fetch, at the model address, now on display.
  task automatic check_fetch(input string tag, input int n0);
    check({tag, "_count"}, log_addr.size(), n0 + 1);
    if (log_addr.size() > n0) begin
      check({tag, "_addr"}, {16'h0, log_addr[n0]}, {16'h0, exp_cur});
      check({tag, "_disp_word"}, disp_word, log_data[log_data.size()-1]);
    end
    check({tag, "_disp_addr"}, {16'h0, disp_addr}, {16'h0, exp_cur});
    check({tag, "_disp_valid"}, {31'h0, disp_valid}, 32'h1);
  endtask

  initial begin
    int n;
    bit is_load;
    RST = 1'b1; halt = 1'b0; base_addr = 16'h0; load_n = 1'b1; step_n = 1'b1;
    mem_wait = 1'b0; mem_load = 32'h0;
    repeat (3) tick();
    RST = 1'b0;
    tick();
    check("rst_ren", {31'h0, mem_ren}, 32'h0);
    check("rst_addr", mem_addr, 32'h0);
    check("rst_word", disp_word, 32'h0);
    check("rst_daddr", {16'h0, disp_addr}, 32'h0);
    check("rst_valid", {31'h0, disp_valid}, 32'h0);

    // Halt rise: first fetch at the aligned switch address.
    base_addr = 16'h0102; load_val = 32'hDEADBEEF; halt = 1'b1;
    tick();
    check("halt_ren", {31'h0, mem_ren}, 32'h1);
    check("halt_addr", mem_addr, 32'h0000_0100);
    tick();
    check("halt_word", disp_word, 32'hDEADBEEF);
    check("halt_daddr", {16'h0, disp_addr}, 32'h0100);
    check("halt_valid", {31'h0, disp_valid}, 32'h1);
    check("halt_ren_off", {31'h0, mem_ren}, 32'h0);
    exp_cur = 16'h0100;
    rand_load = 1'b1;

    // Wrap: 0xFFFC + 4 -> 0x0000, long key hold gives exactly one fetch.
    base_addr = 16'hFFFE; n = log_addr.size();
    do_press(1'b1, 8, 10); exp_cur = 16'hFFFC;
    check_fetch("wrap_load", n);
    n = log_addr.size();
    do_press(1'b0, 10, 10); exp_cur = exp_cur + 16'd4;
    check_fetch("wrap_step", n);

    // Five stall cycles: request held six cycles.
    wait_left = 5; n = log_addr.size();
    do_press(1'b0, 8, 12); exp_cur = exp_cur + 16'd4;
    check_fetch("stall", n);
    if (log_run.size() > 0) check("stall_len", log_run[log_run.size()-1], 6);
    wait_left = 0;

    // Randomized walk.
    for (int i = 0; i < 8; i++) begin
      is_load = 1'($urandom_range(0, 1));
      if (is_load) base_addr = 16'($urandom);
      wait_left = $urandom_range(0, 4);
      n = log_addr.size();
      do_press(is_load, $urandom_range(6, 12), 12);
      exp_cur = is_load ? {base_addr[15:2], 2'b00} : exp_cur + 16'd4;
      check_fetch("rand", n);
      wait_left = 0;
    end

    // Step then load during a long stall: load wins, no extra step fetch.
    base_addr = 16'h0200; wait_left = 60; n = log_addr.size();
    do_press(1'b1, 8, 8);
    base_addr = 16'h0040;
    do_press(1'b0, 8, 8);
    do_press(1'b1, 8, 8);
    repeat (50) tick();
    check("pend_count", log_addr.size(), n + 2);
    if (log_addr.size() >= n + 2) begin
      check("pend_first", {16'h0, log_addr[n]}, 32'h0200);
      check("pend_second", {16'h0, log_addr[n+1]}, 32'h0040);
    end
    exp_cur = 16'h0040; wait_left = 0;
    check("pend_disp", {16'h0, disp_addr}, {16'h0, exp_cur});

    // Two-cycle glitch is rejected.
    n = log_addr.size();
    step_n = 1'b0; tick(); tick(); step_n = 1'b1;
    repeat (15) tick();
    check("glitch_count", log_addr.size(), n);

    // Halt drop during a stalled fetch.
    wait_left = 20; n = log_addr.size();
    step_n = 1'b0;
    repeat (9) tick();
    check("abort_ren_before", {31'h0, mem_ren}, 32'h1);
    check("abort_addr_before", mem_addr, {16'h0, exp_cur + 16'd4});
    halt = 1'b0;
    tick();
    check("abort_ren", {31'h0, mem_ren}, 32'h0);
    check("abort_valid", {31'h0, disp_valid}, 32'h0);
    check("abort_word", disp_word, last_word);
    check("abort_daddr", {16'h0, disp_addr}, {16'h0, exp_cur});
    step_n = 1'b1;
    repeat (10) tick();
    check("abort_count", log_addr.size(), n);
    wait_left = 0;

    // Halt re-assert restarts from the switches.
    base_addr = 16'h0013; halt = 1'b1;
    tick();
    check("restart_ren", {31'h0, mem_ren}, 32'h1);
    check("restart_addr", mem_addr, 32'h0000_0010);
    tick();
    check("restart_daddr", {16'h0, disp_addr}, 32'h0010);
    check("restart_valid", {31'h0, disp_valid}, 32'h1);

    // Idle in SHOW: auto-scan steps once per period, otherwise nothing.
    n = log_addr.size();
    repeat (20) tick();
`ifdef MEMDUMP_AUTOSCAN_EN
    check("scan_count", log_addr.size(), n + 1);
    if (log_addr.size() > n) check("scan_addr", {16'h0, log_addr[n]}, 32'h0014);
`else
    check("scan_count", log_addr.size(), n);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/memdump_viewer.md
# memdump_viewer

Post-halt memory inspection controller for the FPGA build. Sits between the board switches/keys and the system memory read port. It takes the place of the direct switch-to-address, halt-to-REN mapping. Once the CPU halts, it walks memory word by word under debounced key control, holds each read handshake until memory releases it, and presents a latched word and address for the downstream seven-segment/LED decode.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles (10 ms at 50 MHz) before a key change is accepted.
- SCAN_CYCLES, 50000000: auto-scan step period; used only with MEMDUMP_AUTOSCAN_EN.

Ports:
- CLK  in  1  system clock; one clock domain.
- RST  in  1  reset, synchronous, active-high.
- halt  in  1  CPU halted; the viewer is active only while high.
- base_addr  in  16  switch byte address; bits [1:0] are ignored (forced 0).
- load_n  in  1  raw board key, active-low; a press loads base_addr.
- step_n  in  1  raw board key, active-low; a press advances by one word.
- mem_ren  out  1  memory read request.
- mem_addr  out  32  {16'b0, cur_addr}.
- mem_wait  in  1  memory busy; a read completes in the first cycle where mem_ren=1 and mem_wait=0.
- mem_load  in  32  read data, valid in the completing cycle.
- disp_word  out  32  last completed read word.
- disp_addr  out  16  address of disp_word.
- disp_valid  out  1  disp_word/disp_addr hold a completed read for the current halt session.

## Operation
- Key path per key:
  - 2-flop synchronizer, then a stable-count debouncer.
  - The counter resets on any change of the synchronized level.
  - After DEBOUNCE_CYCLES stable cycles, the accepted level updates.
  - A 1->0 accepted transition emits a one-cycle press pulse (load_p / step_p).
- State machine:
  - IDLE:
    - mem_ren=0, disp_valid=0.
    - On halt=1: cur_addr<=base_addr&~3, go to FETCH.
  - FETCH:
    - mem_ren=1, mem_addr driven from cur_addr.
    - When mem_wait=0: disp_word<=mem_load, disp_addr<=cur_addr, disp_valid<=1, go to SHOW.
  - SHOW:
    - mem_ren=0.
    - A pending or new event goes to FETCH: load sets cur_addr<=base_addr&~3; step sets cur_addr<=cur_addr+4.
- cur_addr is 16-bit and wraps modulo 2^16: 0xFFFC+4 = 0x0000.
- Events during FETCH are captured in a one-deep pending register:
  - A load overwrites a pending step.
  - A step never overwrites a pending load.
  - Further steps beyond one are dropped.
- Simultaneous load_p and step_p: load wins; the step is discarded.
- halt=0 in any state:
  - Next state is IDLE and the pending register clears.
  - An in-flight read is abandoned; mem_ren drops the next cycle.
  - disp_word and disp_addr keep their values, but disp_valid=0.
- halt re-asserting restarts from base_addr.

## Timing
- Reset values: mem_ren=0, mem_addr=0, disp_word=0, disp_addr=0, disp_valid=0, state IDLE, pending empty, debouncers' accepted level=1 (released), counters 0.
- Press-to-pulse latency: 2 (sync) + DEBOUNCE_CYCLES + 1 cycles after the raw edge.
- Event pulse in SHOW at cycle t:
  - FETCH and mem_ren=1 at t+1.
  - If mem_wait=0 at t+1, disp_* update and state returns to SHOW at t+2.
  - Each cycle of mem_wait=1 adds one cycle.
- halt rise at t: mem_ren=1 at t+1.
- mem_ren, mem_addr and all disp_* outputs are registered or decoded from registered state only; no combinational path from mem_wait or mem_load to any output.
- mem_addr is stable for the whole time mem_ren=1.

## Configuration
- MEMDUMP_AUTOSCAN_EN defined:
  - A free-running counter in SHOW emits an internal step every SCAN_CYCLES cycles.
  - The counter resets on entering SHOW and on any key event.
  - A manual step_p or load_p in the same cycle takes priority.
- MEMDUMP_AUTOSCAN_EN undefined: no counter logic; stepping is key-only and SCAN_CYCLES is unused.

## Structure
- Shared CPU types package holds:
  - memdump_state_t enum {IDLE, FETCH, SHOW}.
  - memdump_evt_t enum {EVT_NONE, EVT_STEP, EVT_LOAD}, used for the pending register.
  - Word-size constant WBYTES=4.
- Sub-module key_debounce (parameter DEBOUNCE_CYCLES; ports CLK, RST, raw_n, press_p) holds the synchronizer, counter and edge pulse. It is instantiated twice.

## Test plan
Bench uses DEBOUNCE_CYCLES=4 and SCAN_CYCLES=16.
- Reset, then halt=1, base_addr=0x0102, mem_wait=0, mem_load=0xDEADBEEF -> mem_ren=1 with mem_addr=0x00000100 one cycle after halt; disp_word=0xDEADBEEF, disp_addr=0x0100, disp_valid=1 the following cycle.
- In SHOW at cur_addr=0xFFFC, press step_n for 10 cycles -> exactly one fetch at mem_addr=0x00000000.
- Hold mem_wait=1 for 5 cycles during FETCH -> mem_ren and mem_addr held for 6 cycles; disp_word unchanged until the completing cycle.
- During a stalled FETCH, deliver step_p then load_p (base_addr=0x0040) -> the next fetch is at 0x0040 and no 0x0044 fetch follows.
- Glitch step_n low for 2 cycles -> no fetch. Deassert halt mid-FETCH -> mem_ren=0 next cycle, disp_valid=0, disp_word retained.
- With MEMDUMP_AUTOSCAN_EN, idle in SHOW at 0x0010 for 16 cycles -> fetch at 0x0014; without the macro -> no fetch.
